// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, scrub FSM encoding and pointer helper for tmr_regfile
//
// Purpose: one place for the register-file geometry, the replication factor,
//          the scrub pointer bounds and the scrub FSM state encoding.
// Ports:   none (package).

package mips_pkg;

    localparam int NCOPIES = 3;
    localparam int NREGS   = 32;
    localparam int XLEN    = 32;

    // Register 0 is hard-wired to zero, so the scrubber never visits it.
    localparam logic [4:0] PTR_MIN = 5'd1;
    localparam logic [4:0] PTR_MAX = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIX   = 2'd3
    } scrub_state_e;

    function automatic logic [4:0] ptr_next(input logic [4:0] p);
        return (p == PTR_MAX) ? PTR_MIN : p + 5'd1;
    endfunction

endpackage

// File: rtl/vote3.sv
// rtl/vote3.sv - bitwise 2-of-3 majority voter with per-copy mismatch flags
//
// Purpose: votes three 32-bit copies bit by bit and reports which copies
//          disagree with the voted result.
// Ports:
//   in0_i, in1_i, in2_i  32-bit copies 0, 1, 2
//   maj_o                bitwise majority
//   mis_o                bit k set when copy k differs from maj_o in any bit

module vote3 (
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    input  logic [31:0] in2_i,
    output logic [31:0] maj_o,
    output logic [2:0]  mis_o
);

    assign maj_o = (in0_i & in1_i) | (in0_i & in2_i) | (in1_i & in2_i);

    assign mis_o = {|(in2_i ^ maj_o), |(in1_i ^ maj_o), |(in0_i ^ maj_o)};

endmodule

// File: rtl/tmr_regfile.sv
// rtl/tmr_regfile.sv - triple-modular-redundant 32x32 register file with background scrubber
//
// Purpose: MIPS-style 2-read/1-write register file kept in three copies.
//          Reads return the bitwise majority. A background scrubber walks
//          registers 1..31, repairs any copy that was outvoted and records
//          statistics. A fault-inject port flips single bits for test.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   we3, wa3, wd3                  CPU write port (writes all copies)
//   ra1, ra2 / rd1, rd2            combinational voted read ports
//   scrub_en                       run the background scrubber
//   inj_en, inj_copy, inj_addr,
//   inj_bit                        flip one bit of one copy
//   scrub_addr                     register currently being scrubbed
//   fix_count                      saturating count of repairs
//   copy_fault                     sticky, bit k = copy k was outvoted
//   multi_fault                    sticky, two or more copies outvoted at once
//   sweep_done                     one-cycle pulse when the pointer wraps

module tmr_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        scrub_en,
    input  logic        inj_en,
    input  logic [1:0]  inj_copy,
    input  logic [4:0]  inj_addr,
    input  logic [4:0]  inj_bit,
    output logic [4:0]  scrub_addr,
    output logic [15:0] fix_count,
    output logic [2:0]  copy_fault,
    output logic        multi_fault,
    output logic        sweep_done
);

    logic [XLEN-1:0] mem_q [NCOPIES][NREGS];

    scrub_state_e    state_q, state_d;
    logic [4:0]      ptr_q, ptr_d;
    logic [XLEN-1:0] lat_q [NCOPIES];
    logic [XLEN-1:0] lat_d [NCOPIES];
    logic [15:0]     fix_cnt_q, fix_cnt_d;
    logic [2:0]      cf_q, cf_d;
    logic            mf_q, mf_d;
    logic            sweep_q, sweep_d;

    logic            cpu_wr;
    logic            cpu_hit;
    logic            fix_wr;
    logic            inj_ok;
    logic            advance;

    logic [XLEN-1:0] maj1, maj2, scr_maj;
    logic [2:0]      rd1_mis_unused, rd2_mis_unused, scr_mis;

    // ------------------------------------------------------------------
    // Voters: two read ports and the scrub path
    // ------------------------------------------------------------------
    vote3 u_vote_rd1 (
        .in0_i (mem_q[0][ra1]),
        .in1_i (mem_q[1][ra1]),
        .in2_i (mem_q[2][ra1]),
        .maj_o (maj1),
        .mis_o (rd1_mis_unused)
    );

    vote3 u_vote_rd2 (
        .in0_i (mem_q[0][ra2]),
        .in1_i (mem_q[1][ra2]),
        .in2_i (mem_q[2][ra2]),
        .maj_o (maj2),
        .mis_o (rd2_mis_unused)
    );

    // The scrub voter works on the snapshot taken in READ, so anything that
    // lands in the array afterwards is only seen on the next visit.
    vote3 u_vote_scr (
        .in0_i (lat_q[0]),
        .in1_i (lat_q[1]),
        .in2_i (lat_q[2]),
        .maj_o (scr_maj),
        .mis_o (scr_mis)
    );

    assign rd1 = (ra1 == 5'd0) ? '0 : maj1;
    assign rd2 = (ra2 == 5'd0) ? '0 : maj2;

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    assign cpu_wr  = we3 && (wa3 != 5'd0);
    // A CPU write to the address under scrub makes the snapshot stale.
    assign cpu_hit = cpu_wr && (wa3 == ptr_q);

    // Any real write to the injected address wins over the bit flip.
    assign inj_ok = inj_en
                 && (inj_addr != 5'd0)
                 && (inj_copy != 2'd3)
                 && !(cpu_wr && (wa3 == inj_addr))
                 && !(fix_wr && (ptr_q == inj_addr));

    // ------------------------------------------------------------------
    // Scrub FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        fix_cnt_d = fix_cnt_q;
        cf_d      = cf_q;
        mf_d      = mf_q;
        sweep_d   = 1'b0;
        fix_wr    = 1'b0;
        advance   = 1'b0;
        for (int c = 0; c < NCOPIES; c++) begin
            lat_d[c] = lat_q[c];
        end

        case (state_q)
            ST_IDLE: begin
                if (scrub_en) begin
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                // Forward a coincident CPU write so the snapshot matches
                // what the array will hold after this edge.
                for (int c = 0; c < NCOPIES; c++) begin
                    lat_d[c] = cpu_hit ? wd3 : mem_q[c][ptr_q];
                end
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if ((scr_mis != 3'b000) && !cpu_hit) begin
                    state_d = ST_FIX;
                end else begin
                    advance = 1'b1;
                end
            end

            ST_FIX: begin
                advance = 1'b1;
                if (!cpu_hit) begin
                    fix_wr    = 1'b1;
                    fix_cnt_d = (fix_cnt_q == 16'hFFFF) ? fix_cnt_q : fix_cnt_q + 16'd1;
                    cf_d      = cf_q | scr_mis;
                    if ($countones(scr_mis) >= 2) begin
                        mf_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // scrub_en is only sampled between addresses, so dropping it never
        // leaves an address half-scrubbed.
        if (advance) begin
            ptr_d   = ptr_next(ptr_q);
            sweep_d = (ptr_q == PTR_MAX);
            state_d = scrub_en ? ST_READ : ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PTR_MIN;
            fix_cnt_q <= '0;
            cf_q      <= '0;
            mf_q      <= 1'b0;
            sweep_q   <= 1'b0;
            for (int c = 0; c < NCOPIES; c++) begin
                lat_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            fix_cnt_q <= fix_cnt_d;
            cf_q      <= cf_d;
            mf_q      <= mf_d;
            sweep_q   <= sweep_d;
            for (int c = 0; c < NCOPIES; c++) begin
                lat_q[c] <= lat_d[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register array (three copies)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCOPIES; c++) begin
                for (int r = 0; r < NREGS; r++) begin
                    mem_q[c][r] <= '0;
                end
            end
        end else begin
            // fix_wr and cpu_hit are exclusive, so these never collide.
            if (fix_wr) begin
                for (int c = 0; c < NCOPIES; c++) begin
                    mem_q[c][ptr_q] <= scr_maj;
                end
            end
            if (cpu_wr) begin
                for (int c = 0; c < NCOPIES; c++) begin
                    mem_q[c][wa3] <= wd3;
                end
            end
            if (inj_ok) begin
                mem_q[inj_copy][inj_addr][inj_bit] <= ~mem_q[inj_copy][inj_addr][inj_bit];
            end
        end
    end

    assign scrub_addr  = ptr_q;
    assign fix_count   = fix_cnt_q;
    assign copy_fault  = cf_q;
    assign multi_fault = mf_q;
    assign sweep_done  = sweep_q;

endmodule
